// File: rtl/mem_dump_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_dump_ctrl_pkg
//   Shared definitions for the RAM data-port arbiter / memory dump sequencer:
//   sequencer state encoding and default trigger address / dump length.
// -----------------------------------------------------------------------------
package mem_dump_ctrl_pkg;

  // CPU store address that requests the end-of-run dump instead of a write.
  localparam logic [31:0] FINISH_ADDR_DEFAULT = 32'hDEAD10CC;

  // Number of 32-bit words streamed out, starting at word 0.
  localparam int unsigned DUMP_WORDS_DEFAULT = 4096;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_READ    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_PRESENT = 3'd4,
    ST_DONE    = 3'd5
  } dump_state_e;

endpackage

// File: rtl/mem_dump_ctrl.sv
// -----------------------------------------------------------------------------
// mem_dump_ctrl
//   Owns the data port of the dual-port RAM. While running, CPU data-bus
//   accesses pass straight through. A CPU store to FINISH_ADDR or a dump_req
//   pulse holds the CPU, then walks DUMP_WORDS words from address 0 and streams
//   them out over a valid/ready port (one word per 3 cycles at full rate).
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   cpu_addr/wdata/     CPU data bus (byte address, store data, byte mask,
//   wmask/we            store strobe)
//   cpu_rdata           load data to CPU, always ram_rdata
//   cpu_hold            1 while the CPU must be held in reset
//   ram_addr/wdata/     RAM data port (word address, write data, byte mask,
//   wmask/we            write enable)
//   ram_rdata           RAM read data, valid one cycle after ram_addr
//   dump_req            external dump trigger (sampled only while running)
//   dump_valid/ready    dump stream handshake
//   dump_addr/data      byte address and contents of the presented word
//   done                all words accepted; held until reset
// -----------------------------------------------------------------------------
module mem_dump_ctrl
  import mem_dump_ctrl_pkg::*;
#(
  parameter logic [31:0] FINISH_ADDR = FINISH_ADDR_DEFAULT,
  parameter int unsigned DUMP_WORDS  = DUMP_WORDS_DEFAULT,
  parameter int unsigned AW          = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic [3:0]    cpu_wmask,
  input  logic          cpu_we,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_hold,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  output logic [3:0]    ram_wmask,
  output logic          ram_we,
  input  logic [31:0]   ram_rdata,
  input  logic          dump_req,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [31:0]   dump_addr,
  output logic [31:0]   dump_data,
  output logic          done
);

  dump_state_e   state, state_nxt;
  logic [AW-1:0] ptr;
  logic          finish_hit;
  logic          last_word;
  logic          handshake;

  assign finish_hit = (cpu_addr == FINISH_ADDR);
  assign last_word  = (ptr == AW'(DUMP_WORDS - 1));
  assign handshake  = dump_valid && dump_ready;

  // Load data and write payload always pass through; only ram_we is gated.
  assign cpu_rdata = ram_rdata;
  assign ram_wdata = cpu_wdata;
  assign ram_wmask = cpu_wmask;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ram_addr  = ptr;
    ram_we    = 1'b0;
    cpu_hold  = 1'b1;
    done      = 1'b0;
    case (state)
      ST_RUN: begin
        cpu_hold = 1'b0;
        ram_addr = cpu_addr[AW+1:2];
        // The finishing store is a trigger, never a RAM write.
        ram_we   = cpu_we && !finish_hit;
        if ((cpu_we && finish_hit) || dump_req) state_nxt = ST_FLUSH;
      end
      ST_FLUSH:   state_nxt = ST_READ;
      ST_READ:    state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_PRESENT;
      ST_PRESENT: begin
        if (handshake) state_nxt = last_word ? ST_DONE : ST_READ;
      end
      ST_DONE:    done = 1'b1;
      default:    state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= '0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_addr  <= '0;
    end else begin
      case (state)
        ST_FLUSH: ptr <= '0;
        // ram_addr was ptr in READ, so ram_rdata now holds word ptr.
        ST_CAPTURE: begin
          dump_data  <= ram_rdata;
          dump_addr  <= 32'(ptr) << 2;
          dump_valid <= 1'b1;
        end
        ST_PRESENT: begin
          if (handshake) begin
            dump_valid <= 1'b0;
            // ptr stops at the last word; it never wraps.
            if (!last_word) ptr <= ptr + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_ctrl.sv
module tb_mem_dump_ctrl;
  import mem_dump_ctrl_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;
  localparam logic [31:0] FIN = 32'hDEAD10CC;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   cpu_addr, cpu_wdata;
  logic [3:0]    cpu_wmask;
  logic          cpu_we;
  logic [31:0]   cpu_rdata;
  logic          cpu_hold;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [3:0]    ram_wmask;
  logic          ram_we;
  logic [31:0]   ram_rdata;
  logic          dump_req, dump_valid, dump_ready;
  logic [31:0]   dump_addr, dump_data;
  logic          done;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  logic [31:0] exp_data [0:DW-1];

  always #5 clk = ~clk;

  mem_dump_ctrl #(.FINISH_ADDR(FIN), .DUMP_WORDS(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask),
    .cpu_we(cpu_we), .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask),
    .ram_we(ram_we), .ram_rdata(ram_rdata),
    .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data), .done(done)
  );

  // Synchronous-read RAM data port with byte write mask.
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_wmask[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
  end

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] nw,
                                        input logic [3:0]  m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_we   = 1'b0;
    dump_req = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    dump_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Consume the dump stream. stop_idx >= 0 returns (ready low) while that
  // word is being presented; otherwise runs to done and checks the count.
  task automatic run_dump(input bit rand_ready, input int stop_idx);
    int          idx = 0;
    bit          pv  = 1'b0;
    bit          pr  = 1'b0;
    logic [31:0] pd  = '0;
    logic [31:0] pa  = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      if (done) break;
      if (pv && !pr) begin
        check("hold_valid", 32'(dump_valid), 32'd1);
        check("hold_data", dump_data, pd);
        check("hold_addr", dump_addr, pa);
      end
      if (dump_valid) begin
        if (idx >= int'(DW)) begin
          check("word_overrun", 32'(idx), 32'(DW - 1));
        end else begin
          check("dump_addr", dump_addr, 32'(idx) * 4);
          check("dump_data", dump_data, exp_data[idx]);
        end
        if (idx == stop_idx) begin
          dump_ready = 1'b0;
          return;
        end
        pd = dump_data;
        pa = dump_addr;
      end
      dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      pv = dump_valid;
      pr = dump_ready;
      if (dump_valid && dump_ready) idx++;
    end
    check("dump_done", 32'(done), 32'd1);
    check("dump_count", 32'(idx), 32'(DW));
    dump_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    int unsigned w;
    logic [31:0] a, d;
    logic [3:0]  m;

    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     <= '0;
      ref_mem[i]  = '0;
    end
    cpu_addr = '0; cpu_wdata = '0; cpu_wmask = '0;
    do_reset();
    reset = 1'b1;
    tick();
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_valid", 32'(dump_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", dump_data, 32'd0);
    reset = 1'b0;

    // Plain store and load-back.
    tick();
    cpu_addr = 32'h10; cpu_wdata = 32'h12345678; cpu_wmask = 4'hF; cpu_we = 1'b1;
    #1;
    check("st_we", 32'(ram_we), 32'd1);
    check("st_addr", 32'(ram_addr), 32'd4);
    check("st_hold", 32'(cpu_hold), 32'd0);
    ref_mem[4] = 32'h12345678;
    tick();
    cpu_we = 1'b0;
    tick();
    check("ld_data", cpu_rdata, 32'h12345678);

    // Random masked stores to words 8..15 with junk in the ignored address bits.
    for (int k = 0; k < 8; k++) begin
      w = $urandom_range(8, 15);
      a = ($urandom & 32'hFFFF_C000) | (w << 2) | ($urandom & 32'h3);
      d = $urandom;
      m = 4'($urandom);
      tick();
      cpu_addr = a; cpu_wdata = d; cpu_wmask = m; cpu_we = 1'b1;
      #1;
      check("rnd_st_addr", 32'(ram_addr), w);
      ref_mem[w] = merge(ref_mem[w], d, m);
      tick();
      cpu_we = 1'b0; cpu_addr = w << 2;
      tick();
      check("rnd_ld_data", cpu_rdata, ref_mem[w]);
    end

    // Preload dump region with i*0x11.
    tick();
    for (int i = 0; i < int'(DW); i++) begin
      mem[i]      <= 32'(i) * 32'h11;
      exp_data[i]  = 32'(i) * 32'h11;
    end

    // FINISH_ADDR store triggers the dump; latency check then full-rate dump.
    tick();
    cpu_addr = FIN; cpu_wdata = 32'hBAD0BAD0; cpu_wmask = 4'hF; cpu_we = 1'b1;
    #1;
    check("fin_no_we", 32'(ram_we), 32'd0);
    tick();
    idle();
    check("fin_hold", 32'(cpu_hold), 32'd1);
    check("flush_valid", 32'(dump_valid), 32'd0);
    lat = 0;
    while (!dump_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'd3);
    check("first_addr", dump_addr, 32'd0);
    run_dump(1'b0, -1);

    // DONE is sticky: triggers and stores ignored.
    for (int k = 0; k < 3; k++) begin
      dump_req = 1'b1; cpu_addr = 32'h20; cpu_we = 1'b1;
      #1;
      check("done_no_we", 32'(ram_we), 32'd0);
      tick();
      check("done_held", 32'(done), 32'd1);
      check("done_hold", 32'(cpu_hold), 32'd1);
      check("done_valid", 32'(dump_valid), 32'd0);
    end
    idle();

    // Reset in PRESENT at word 3, random ready.
    do_reset();
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    run_dump(1'b1, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", 32'(dump_valid), 32'd0);
    check("mid_rst_hold", 32'(cpu_hold), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    cpu_addr = 32'h40; cpu_wdata = 32'hCAFEF00D; cpu_wmask = 4'hF; cpu_we = 1'b1;
    #1;
    check("post_rst_we", 32'(ram_we), 32'd1);
    tick();
    idle();
    tick();
    check("post_rst_ld", cpu_rdata, 32'hCAFEF00D);

    // Random contents, random ready, dump_req trigger.
    do_reset();
    for (int i = 0; i < int'(DW); i++) begin
      d = $urandom;
      mem[i]      <= d;
      exp_data[i]  = d;
    end
    tick();
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    run_dump(1'b1, -1);

    // Both triggers in one cycle: a single dump.
    do_reset();
    dump_req = 1'b1; cpu_addr = FIN; cpu_we = 1'b1;
    tick();
    idle();
    run_dump(1'b0, -1);
    tick();
    check("dual_done", 32'(done), 32'd1);

    // Ordinary store alongside dump_req still commits.
    do_reset();
    dump_req = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h5A5AA5A5; cpu_wmask = 4'h3; cpu_we = 1'b1;
    #1;
    check("req_st_we", 32'(ram_we), 32'd1);
    ref_mem[12] = merge(ref_mem[12], 32'h5A5AA5A5, 4'h3);
    tick();
    idle();
    check("req_st_hold", 32'(cpu_hold), 32'd1);
    do_reset();
    cpu_addr = 32'h30;
    tick();
    check("req_st_ld", cpu_rdata, ref_mem[12]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
